l1_mem_arbiter: RTL and testbench

- Shares the single physical-memory line port between the L1 instruction cache and the L1 data cache miss/writeback engines.
- Sits below both L1 caches, between their pmem-side ports and the L2/physical memory. It serialises line transactions, latches the granted request, and routes the response back to the winner.
- Default policy is fixed data-cache priority; an optional fairness mode alternates grants under contention.

---
 rtl/l1_mem_arbiter.sv | 115 +++++++++++
 tb/tb_l1_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one physical-memory line port between the L1
// icache and dcache. One transaction at a time; the granted request is
// latched into the pmem_* registers and the response is routed back to
// the winner with zero added latency.
// Optional macro ARB_FAIR_EN: round-robin on contention instead of fixed
// dcache-over-icache priority.
module l1_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  // Line addresses are 16-byte aligned; the offset bits are zeroed on latch.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(4'hF);

  state_t state, state_nxt;
  logic   i_req, d_req, pick_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_FAIR_EN
  // 1 = dcache held the last grant, 0 = icache.
  logic last_grant;

  // Remember who won the most recent grant, contended or not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      last_grant <= 1'b0;
    else if (state == IDLE && (i_req || d_req)) last_grant <= pick_d;
  end

  // Under contention the client that did not win last time goes next.
  assign pick_d = d_req & (~i_req | ~last_grant);
`else
  // Fixed priority: any dcache request beats the icache.
  assign pick_d = d_req;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and client response routing; a stray pmem_resp in IDLE is ignored.
  always_comb begin
    state_nxt   = state;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (state)
      IDLE:  if (i_req || d_req) state_nxt = pick_d ? GNT_D : GNT_I;
      GNT_I: begin
        i_pmem_resp = pmem_resp;
        if (pmem_resp) state_nxt = IDLE;
      end
      GNT_D: begin
        d_pmem_resp = pmem_resp;
        if (pmem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's request on grant; drop read/write once memory answers.
  // A dcache read+write together is taken as a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else if (state == IDLE) begin
      if (i_req || d_req) begin
        if (pick_d) begin
          pmem_address <= d_pmem_address & LINE_MASK;
          pmem_wdata   <= d_pmem_wdata;
          pmem_write   <= d_pmem_write;
          pmem_read    <= ~d_pmem_write;
        end else begin
          pmem_address <= i_pmem_address & LINE_MASK;
          pmem_wdata   <= '0;
          pmem_write   <= 1'b0;
          pmem_read    <= 1'b1;
        end
      end
    end else if (pmem_resp) begin
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: directed steps from the feature list followed
// by randomized client/memory traffic checked against a cycle-level model.
module tb_l1_mem_arbiter;

`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read, d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_asrt = 0;
  int n_fail = 0;

  l1_mem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; pmem_resp = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] aa, wd, rnd;
    // model state for the random phase
    bit   m_busy, m_who, m_last, pick, resp_prev;
    bit   exp_rd, exp_wr, i_got, d_got, exp_i, exp_d;
    bit   i_pend, d_pend, d_kind, d_both;
    logic [15:0]  i_a, d_a, exp_addr;
    logic [127:0] d_wd, exp_wd;
    int   lat;

    aa = {16{8'hAA}};
    wd = 128'h0123456789ABCDEF0123456789ABCDEF;
    i_pmem_address = 0; d_pmem_address = 0; d_pmem_wdata = 0; pmem_rdata = 0;

    // ---- reset state
    reset_n = 1'b0;
    i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; pmem_resp = 0;
    repeat (2) @(negedge clk);
    chk("rst_read",  pmem_read, 0);
    chk("rst_write", pmem_write, 0);
    chk("rst_addr",  pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_iresp", i_pmem_resp, 0);
    chk("rst_dresp", d_pmem_resp, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- lone icache fill
    i_pmem_read = 1; i_pmem_address = 16'h1234;
    @(negedge clk);
    chk("ifill_read", pmem_read, 1);
    chk("ifill_write", pmem_write, 0);
    chk("ifill_addr", pmem_address, 16'h1230);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ifill_hold", pmem_read, 1);
      chk("ifill_noresp", i_pmem_resp, 0);
    end
    pmem_resp = 1; pmem_rdata = aa;
    #1;
    chk("ifill_iresp", i_pmem_resp, 1);
    chk("ifill_data", i_pmem_rdata, aa);
    chk("ifill_dresp", d_pmem_resp, 0);
    @(negedge clk);
    pmem_resp = 0; i_pmem_read = 0;
    chk("ifill_done", pmem_read, 0);

    // ---- dcache writeback
    @(negedge clk);
    d_pmem_write = 1; d_pmem_address = 16'h4010; d_pmem_wdata = wd;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wb_write", pmem_write, 1);
      chk("wb_read", pmem_read, 0);
      chk("wb_addr", pmem_address, 16'h4010);
      chk("wb_wdata", pmem_wdata, wd);
    end
    pmem_resp = 1;
    #1;
    chk("wb_dresp", d_pmem_resp, 1);
    chk("wb_iresp", i_pmem_resp, 0);
    @(negedge clk);
    pmem_resp = 0; d_pmem_write = 0;
    chk("wb_done", pmem_write, 0);

    // ---- simultaneous reads (fresh reset so either policy starts with dcache)
    do_reset();
    i_pmem_read = 1; i_pmem_address = 16'h2222;
    d_pmem_read = 1; d_pmem_address = 16'h3333;
    @(negedge clk);
    chk("both_first_addr", pmem_address, 16'h3330);
    chk("both_first_read", pmem_read, 1);
    pmem_resp = 1;
    #1;
    chk("both_dresp", d_pmem_resp, 1);
    chk("both_iresp0", i_pmem_resp, 0);
    @(negedge clk);
    pmem_resp = 0; d_pmem_read = 0;
    chk("both_idle_gap", pmem_read, 0);
    @(negedge clk);
    chk("both_second_read", pmem_read, 1);
    chk("both_second_addr", pmem_address, 16'h2220);
    pmem_resp = 1;
    #1;
    chk("both_iresp", i_pmem_resp, 1);
    @(negedge clk);
    pmem_resp = 0; i_pmem_read = 0;

    // ---- reset mid-transaction
    @(negedge clk);
    d_pmem_read = 1; d_pmem_address = 16'h8888; d_pmem_wdata = wd;
    repeat (2) @(negedge clk);
    chk("mid_pre_read", pmem_read, 1);
    reset_n = 0;
    #1;
    chk("mid_read", pmem_read, 0);
    chk("mid_write", pmem_write, 0);
    chk("mid_addr", pmem_address, 0);
    chk("mid_wdata", pmem_wdata, 0);
    d_pmem_read = 0;
    @(negedge clk);
    reset_n = 1;
    i_pmem_read = 1; i_pmem_address = 16'h5678;
    @(negedge clk);
    chk("mid_after_read", pmem_read, 1);
    chk("mid_after_addr", pmem_address, 16'h5670);
    pmem_resp = 1;
    #1;
    chk("mid_after_iresp", i_pmem_resp, 1);
    @(negedge clk);
    pmem_resp = 0; i_pmem_read = 0;

    // ---- stray response in IDLE
    @(negedge clk);
    pmem_resp = 1;
    #1;
    chk("stray_iresp", i_pmem_resp, 0);
    chk("stray_dresp", d_pmem_resp, 0);
    @(negedge clk);
    pmem_resp = 0;
    chk("stray_read", pmem_read, 0);
    chk("stray_write", pmem_write, 0);
    i_pmem_read = 1; i_pmem_address = 16'h0AB7;
    @(negedge clk);
    chk("stray_grant", pmem_read, 1);
    chk("stray_addr", pmem_address, 16'h0AB0);
    pmem_resp = 1;
    @(negedge clk);
    pmem_resp = 0; i_pmem_read = 0;

    // ---- randomized traffic vs. model
    do_reset();
    m_busy = 0; m_who = 0; m_last = 0; resp_prev = 0;
    exp_rd = 0; exp_wr = 0; i_got = 0; d_got = 0;
    i_pend = 0; d_pend = 0; d_kind = 0; d_both = 0;
    i_a = 0; d_a = 0; d_wd = 0; exp_addr = 0; exp_wd = 0; lat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      // what the arbiter must have done on the edge just passed
      if (m_busy) begin
        if (resp_prev) begin m_busy = 0; exp_rd = 0; exp_wr = 0; end
      end else if (i_pend || d_pend) begin
        pick   = d_pend && (!i_pend || !FAIR || !m_last);
        m_busy = 1; m_who = pick; m_last = pick;
        exp_wr = pick && d_kind;
        exp_rd = !exp_wr;
        exp_addr = (pick ? d_a : i_a) & 16'hFFF0;
        exp_wd = d_wd;
        lat = $urandom_range(0, 4);
      end
      chk("rnd_read", pmem_read, exp_rd);
      chk("rnd_write", pmem_write, exp_wr);
      if (m_busy) chk("rnd_addr", pmem_address, exp_addr);
      if (exp_wr) chk("rnd_wdata", pmem_wdata, exp_wd);

      // clients: drop for one cycle after resp, otherwise maybe request
      if (i_got) i_pend = 0;
      else if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_a = 16'($urandom);
      end
      if (d_got) d_pend = 0;
      else if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_a = 16'($urandom);
        d_kind = $urandom_range(0, 1) == 1;
        d_both = d_kind && ($urandom_range(0, 5) == 0);
        d_wd = {$urandom, $urandom, $urandom, $urandom};
      end
      i_pmem_read = i_pend; i_pmem_address = i_a;
      d_pmem_write = d_pend && d_kind;
      d_pmem_read = d_pend && (!d_kind || d_both);
      d_pmem_address = d_a; d_pmem_wdata = d_wd;

      // memory: answer after a random latency; occasional stray resp in IDLE
      rnd = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata = rnd;
      if (m_busy) begin
        if (lat == 0) pmem_resp = 1;
        else begin lat--; pmem_resp = 0; end
      end else pmem_resp = ($urandom_range(0, 7) == 0);
      #1;
      exp_i = m_busy && !m_who && pmem_resp;
      exp_d = m_busy && m_who && pmem_resp;
      chk("rnd_iresp", i_pmem_resp, exp_i);
      chk("rnd_dresp", d_pmem_resp, exp_d);
      if (pmem_resp) begin
        chk("rnd_irdata", i_pmem_rdata, rnd);
        chk("rnd_drdata", d_pmem_rdata, rnd);
      end
      resp_prev = m_busy && pmem_resp;
      i_got = exp_i; d_got = exp_d;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
